swap_sequencer: RTL and testbench

//  ID-stage micro-op sequencer between the IF/ID register and the control unit.

---
 rtl/swap_sequencer_pkg.sv | 26 ++
 rtl/swap_sequencer_sat_counter.sv | 19 +
 rtl/swap_sequencer.sv | 104 ++++++++++
 tb/tb_swap_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/swap_sequencer_pkg.sv
// Shared definitions for the ID-stage SWP micro-op sequencer: opcodes,
// execution command codes, swap-phase select encodings and FSM states.
package swap_sequencer_pkg;

  localparam logic [5:0] OPC_NOP = 6'b000000;
  localparam logic [5:0] OPC_ADD = 6'b000001;
  localparam logic [5:0] OPC_SWP = 6'b111111;

  typedef enum logic [3:0] {
    EXEC_NONE       = 4'b0000,
    EXEC_SWP_FIRST  = 4'b1100,
    EXEC_SWP_SECOND = 4'b1101
  } exec_cmd_t;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'b00,
    SEL_FIRST  = 2'b01,
    SEL_SECOND = 2'b10
  } swp_sel_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SWP2 = 1'b1
  } state_t;

endpackage

// File: rtl/swap_sequencer_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/swap_sequencer.sv
// ID-stage sequencer: expands SWP into FIRST/SECOND micro-ops, freezes PC and
// IF/ID while a SWP is in flight, and passes all other opcodes straight through.
module swap_sequencer
  import swap_sequencer_pkg::*;
#(
  parameter int                  OPCODE_W   = 6,
  parameter logic [OPCODE_W-1:0] SWP_OPCODE = OPC_SWP,
  parameter int                  CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                hazard_stall,
  input  logic                flush,
  output logic [OPCODE_W-1:0] uop_opcode,
  output logic                uop_valid,
  output logic [1:0]          swp_sel,
  output logic [3:0]          swp_exec_cmd,
  output logic                freeze,
  output logic                swp_busy,
  output logic [CNT_W-1:0]    swp_retired
);

  state_t state, state_next;
  logic   retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!flush && !hazard_stall && instr_valid && (opcode == SWP_OPCODE)) begin
          state_next = S_SWP2;
        end
      end
      S_SWP2: begin
        // A stall keeps the phase; flush or a completed SECOND both return to idle.
        if (flush || !hazard_stall) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign retire = (state == S_SWP2) && !flush && !hazard_stall;

  always_comb begin
    uop_opcode   = '0;
    uop_valid    = 1'b0;
    swp_sel      = SEL_NONE;
    swp_exec_cmd = EXEC_NONE;
    freeze       = 1'b0;
    swp_busy     = 1'b0;
    // Outputs are forced to the NOP bubble for as long as reset is held.
    if (!rst) begin
      swp_busy = (state == S_SWP2);
      if (!flush) begin
        if (hazard_stall) begin
          freeze = 1'b1;
        end else begin
          case (state)
            S_IDLE: begin
              if (instr_valid) begin
                uop_opcode = opcode;
                uop_valid  = 1'b1;
                if (opcode == SWP_OPCODE) begin
                  swp_sel      = SEL_FIRST;
                  swp_exec_cmd = EXEC_SWP_FIRST;
                  freeze       = 1'b1;
                end
              end
            end
            S_SWP2: begin
              uop_opcode   = SWP_OPCODE;
              uop_valid    = 1'b1;
              swp_sel      = SEL_SECOND;
              swp_exec_cmd = EXEC_SWP_SECOND;
            end
            default: ;
          endcase
        end
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_retired (
    .clk  (clk),
    .rst  (rst),
    .inc  (retire),
    .count(swp_retired)
  );

endmodule

// File: tb/tb_swap_sequencer.sv
// Directed bench for swap_sequencer (CNT_W=2 so saturation is reachable).
module tb_swap_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [5:0] opcode;
  logic       hazard_stall;
  logic       flush;
  logic [5:0] uop_opcode;
  logic       uop_valid;
  logic [1:0] swp_sel;
  logic [3:0] swp_exec_cmd;
  logic       freeze;
  logic       swp_busy;
  logic [1:0] swp_retired;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] SWP = 6'b111111;
  localparam logic [5:0] ADD = 6'b000001;

  always #5 clk = ~clk;

  swap_sequencer #(
    .OPCODE_W  (6),
    .SWP_OPCODE(6'b111111),
    .CNT_W     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .hazard_stall(hazard_stall),
    .flush       (flush),
    .uop_opcode  (uop_opcode),
    .uop_valid   (uop_valid),
    .swp_sel     (swp_sel),
    .swp_exec_cmd(swp_exec_cmd),
    .freeze      (freeze),
    .swp_busy    (swp_busy),
    .swp_retired (swp_retired)
  );

  // Inputs change 1 time unit after a rising edge; outputs settle 2 units later.
  task automatic drive(input logic v, input logic [5:0] op, input logic st, input logic fl);
    instr_valid  = v;
    opcode       = op;
    hazard_stall = st;
    flush        = fl;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [5:0] e_op, input logic e_valid,
                            input logic [1:0] e_sel, input logic [3:0] e_cmd,
                            input logic e_freeze, input logic e_busy);
    logic [14:0] obs, exp;
    obs = {uop_opcode, uop_valid, swp_sel, swp_exec_cmd, freeze, swp_busy};
    exp = {e_op, e_valid, e_sel, e_cmd, e_freeze, e_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed{op,v,sel,cmd,frz,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [1:0] e_cnt);
    checks++;
    assert (swp_retired === e_cnt) else begin
      errors++;
      $error("FAIL %s observed swp_retired=%0d expected=%0d", tag, swp_retired, e_cnt);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, ADD, 1'b0, 1'b0);
    check_outs("reset_gates_outputs", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    check_cnt("reset_count", 2'd0);
    step();
    rst = 1'b0;

    // 1. Reset mid-SWP
    drive(1'b1, SWP, 1'b0, 1'b0);
    check_outs("t1_first", SWP, 1'b1, 2'b01, 4'b1100, 1'b1, 1'b0);
    step();
    check_outs("t1_second_pending", SWP, 1'b1, 2'b10, 4'b1101, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_outs("t1_async_reset", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    check_cnt("t1_reset_count", 2'd0);
    step();
    rst = 1'b0;
    drive(1'b0, SWP, 1'b0, 1'b0);
    check_outs("t1_no_second", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    check_cnt("t1_count_after", 2'd0);
    step();

    // 2. Single SWP, no stalls
    drive(1'b1, SWP, 1'b0, 1'b0);
    check_outs("t2_first", SWP, 1'b1, 2'b01, 4'b1100, 1'b1, 1'b0);
    step();
    drive(1'b1, SWP, 1'b0, 1'b0);
    check_outs("t2_second", SWP, 1'b1, 2'b10, 4'b1101, 1'b0, 1'b1);
    check_cnt("t2_count_before_edge", 2'd0);
    step();
    check_cnt("t2_count", 2'd1);
    drive(1'b0, 6'h00, 1'b0, 1'b0);
    check_outs("t2_idle_bubble", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    step();

    // 3. Stall for 3 cycles in S_SWP2
    drive(1'b1, SWP, 1'b0, 1'b0);
    check_outs("t3_first", SWP, 1'b1, 2'b01, 4'b1100, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SWP, 1'b1, 1'b0);
      check_outs("t3_stall_bubble", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1);
      step();
    end
    check_cnt("t3_count_during", 2'd1);
    drive(1'b1, SWP, 1'b0, 1'b0);
    check_outs("t3_second", SWP, 1'b1, 2'b10, 4'b1101, 1'b0, 1'b1);
    step();
    check_cnt("t3_count", 2'd2);

    // Idle-state stall, invalid-SWP, and flush behaviour
    drive(1'b1, ADD, 1'b1, 1'b0);
    check_outs("idle_stall", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b0);
    step();
    drive(1'b0, SWP, 1'b0, 1'b0);
    check_outs("idle_invalid_swp", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    step();
    drive(1'b1, SWP, 1'b1, 1'b1);
    check_outs("idle_flush", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    step();
    drive(1'b0, 6'h00, 1'b0, 1'b0);
    check_outs("idle_stays_idle", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    step();

    // 4. Flush beats stall in S_SWP2
    drive(1'b1, SWP, 1'b0, 1'b0);
    check_outs("t4_first", SWP, 1'b1, 2'b01, 4'b1100, 1'b1, 1'b0);
    step();
    drive(1'b1, SWP, 1'b1, 1'b1);
    check_outs("t4_flush_stall", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b1);
    step();
    drive(1'b0, 6'h00, 1'b0, 1'b0);
    check_outs("t4_back_idle", 6'h00, 1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    check_cnt("t4_count_unchanged", 2'd2);
    step();

    // 5. Back-to-back SWPs with an ADD, saturating at 3
    reset_pulse();
    check_cnt("t5_cleared", 2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, SWP, 1'b0, 1'b0);
      check_outs("t5_first", SWP, 1'b1, 2'b01, 4'b1100, 1'b1, 1'b0);
      step();
      drive(1'b1, SWP, 1'b0, 1'b0);
      check_outs("t5_second", SWP, 1'b1, 2'b10, 4'b1101, 1'b0, 1'b1);
      step();
      check_cnt("t5_count", (i >= 2) ? 2'd3 : 2'(i + 1));
      if (i == 0) begin
        drive(1'b1, ADD, 1'b0, 1'b0);
        check_outs("t5_add_pass", ADD, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0);
        step();
      end
    end
    drive(1'b0, 6'h00, 1'b0, 1'b0);
    check_cnt("t5_saturated", 2'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
